conv_window_mac: RTL and testbench
==================================

CONV_WINDOW_MAC -- requirements
Module: conv_window_mac

Interface
REQ-001 The module SHALL have parameter KERNEL_SIZE, default 3, meaning window edge length K.
REQ-002 The module SHALL have parameter DATA_SIZE, default 8, meaning unsigned pixel width D.
REQ-003 The module SHALL have parameter ROW_SIZE, default 28, meaning image row length in pixels.
REQ-004 The module SHALL have parameter WEIGHT_SIZE, default 8, meaning signed two's-complement weight width W.
REQ-005 The module SHALL have port clock, input, width 1; it is the single clock, and all logic is on its rising edge.
REQ-006 The module SHALL have port resetn, input, width 1; it is an asynchronous, active-low reset.
REQ-007 The module SHALL have port window_in, input, width K*K*D, carrying the flattened KxK pixel window.
REQ-008 The module SHALL have port window_valid, input, width 1; it qualifies window_in, and one cycle equals one pixel shift.
REQ-009 The module SHALL have port weight_in, input, width W, carrying serial weight data.
REQ-010 The module SHALL have port weight_valid, input, width 1; it qualifies weight_in.
REQ-011 The module SHALL have port weights_ready, output, width 1; it is high once all K*K weights are loaded.
REQ-012 The module SHALL have port pixel_out, output, width ACC = D+W+1+clog2(K*K), carrying the signed convolution result.
REQ-013 The module SHALL have port pixel_valid, output, width 1; it qualifies pixel_out.

Function
REQ-014 Window layout: row r (0 = oldest/top) SHALL occupy bits [(r+1)*K*D-1 : r*K*D]; within a row, element c (0 = leftmost/oldest) SHALL occupy the row base plus [(c+1)*D-1 : c*D].
REQ-015 Weight loading: each cycle with weight_valid=1 and window_valid=0 SHALL write weight_in to index wptr (index = r*K+c) and then increment wptr; weight_valid SHALL be ignored while window_valid=1.
REQ-016 When wptr reaches K*K, weights_ready SHALL go high the next cycle and wptr SHALL wrap to 0; a further load SHALL overwrite index 0 onward and deassert weights_ready until K*K new weights have been written.
REQ-017 Windows SHALL be accepted only when window_valid=1 and weights_ready=1; all other window cycles are dropped.
REQ-018 Column tracking: a column counter SHALL load K-1 on the first accepted cycle after window_valid was 0, increment on each accepted cycle, and wrap from ROW_SIZE-1 to 0.
REQ-019 Accepted windows whose column counter is less than K-1 straddle a row boundary and SHALL NOT produce pixel_valid; they still consume a column step.
REQ-020 Arithmetic: each pixel SHALL be zero-extended to D+1 bits and multiplied signed by its weight; the K*K products SHALL be summed sign-extended to ACC bits with no overflow possible.
REQ-021 Pipeline: stage 1 SHALL register the products; stage 2 SHALL register the sum. pixel_valid SHALL rise exactly 2 cycles after the accepting edge. Throughput SHALL be one window per cycle with no stall.
REQ-022 window_valid falling SHALL NOT flush the pipeline; in-flight results SHALL still emerge.
REQ-023 Per image row in steady state, exactly ROW_SIZE-K+1 outputs SHALL be produced.

Reset
REQ-024 While resetn=0, pixel_out=0, pixel_valid=0, weights_ready=0, wptr=0, the column counter=0, and all pipeline valids=0; weight storage contents SHALL be don't-care.
REQ-025 Reset asserted mid-operation SHALL discard in-flight results and require a full weight reload.

Configuration
REQ-026 With CONV_RELU_EN defined, stage 2 SHALL clamp negative sums to 0 before registering them (latency unchanged); without it, pixel_out SHALL be the raw signed sum.

Structure
REQ-027 Package conv_pkg SHALL hold the ACC width function (clog2 based), the product-width constant, and the ROW/COL index widths, shared with the window producer.
REQ-028 Sub-module mac_adder_tree SHALL implement the registered K*K-input signed summation; the top level holds weight storage, counters, product stage, and ReLU.

Verification (K=3, ROW_SIZE=28, D=8, W=8)
REQ-029 Load 9 weights of 1, then present windows of all 2s with valid held -> pixel_out=18, two cycles after the accepting edge.
REQ-030 Center weight -1, others 0, center pixel 200 -> pixel_out=-200; with CONV_RELU_EN defined -> 0.
REQ-031 Hold window_valid for 56 cycles -> exactly 52 pixel_valid pulses, with gaps of 2 cycles at each row wrap.
REQ-032 Load 5 weights, then assert resetn=0 -> weights_ready=0; windows are ignored until 9 new weights are loaded.
REQ-033 Drop window_valid for 1 cycle mid-row -> 2 in-flight results still emerge; on resume, the column counter restarts at 2 and output resumes immediately.
REQ-034 Assert weight_valid concurrent with window_valid -> the weight is ignored, and wptr and outputs are unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared sizing helpers for the convolution window datapath and its window producer.
package conv_pkg;

  // One extra product bit: unsigned pixels are zero-extended into the signed domain.
  localparam int unsigned PROD_SIGN_BITS = 1;

  function automatic int unsigned prod_width(input int unsigned d, input int unsigned w);
    return d + w + PROD_SIGN_BITS;
  endfunction

  // Sum of k*k products needs clog2(k*k) guard bits on top of the product width.
  function automatic int unsigned acc_width(input int unsigned k, input int unsigned d,
                                            input int unsigned w);
    return prod_width(d, w) + $clog2(k * k);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_ROW_SIZE = 28;
  localparam int unsigned ROW_IDX_W    = idx_width(DEF_ROW_SIZE);
  localparam int unsigned COL_IDX_W    = idx_width(DEF_ROW_SIZE);

endpackage

// File: rtl/mac_adder_tree.sv
// Registered signed summation of N product terms, with optional negative clamp before the register.
module mac_adder_tree
  import conv_pkg::*;
#(
  parameter int unsigned N         = 9,
  parameter int unsigned IN_W      = 17,
  parameter int unsigned OUT_W     = 21,
  parameter bit          CLAMP_NEG = 1'b0
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic signed [IN_W-1:0]  terms [N],
  input  logic                    in_valid,
  output logic signed [OUT_W-1:0] sum,
  output logic                    out_valid
);

  logic signed [OUT_W-1:0] sum_d, sum_q;
  logic                    valid_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N; i++) begin
      sum_d = sum_d + {{(OUT_W - IN_W){terms[i][IN_W-1]}}, terms[i]};
    end
    if (CLAMP_NEG && sum_d[OUT_W-1]) begin
      sum_d = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q <= sum_d;
      end
    end
  end

  assign sum       = sum_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/conv_window_mac.sv
// KxK convolution MAC over a streamed pixel window: serial weight load, product stage, adder tree.
// Define CONV_RELU_EN to clamp negative sums to zero in the summation stage.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned DATA_SIZE   = 8,
  parameter int unsigned ROW_SIZE    = 28,
  parameter int unsigned WEIGHT_SIZE = 8
) (
  input  logic                                                clock,
  input  logic                                                resetn,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE-1:0]        window_in,
  input  logic                                                window_valid,
  input  logic signed [WEIGHT_SIZE-1:0]                       weight_in,
  input  logic                                                weight_valid,
  output logic                                                weights_ready,
  output logic signed [acc_width(KERNEL_SIZE, DATA_SIZE, WEIGHT_SIZE)-1:0] pixel_out,
  output logic                                                pixel_valid
);

  localparam int unsigned N      = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned ACC    = acc_width(KERNEL_SIZE, DATA_SIZE, WEIGHT_SIZE);
  localparam int unsigned PROD_W = prod_width(DATA_SIZE, WEIGHT_SIZE);
  localparam int unsigned PTR_W  = idx_width(N);
  localparam int unsigned COL_W  = idx_width(ROW_SIZE);

`ifdef CONV_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  logic signed [WEIGHT_SIZE-1:0] weight_mem_q [N];
  logic [PTR_W-1:0]              wptr_q;
  logic                          ready_q;
  logic                          load;
  logic                          accept;

  // Window traffic has priority over the weight port.
  assign load   = weight_valid && !window_valid;
  assign accept = window_valid && ready_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      ready_q <= 1'b0;
    end else if (load) begin
      if (wptr_q == PTR_W'(N - 1)) begin
        wptr_q  <= '0;
        ready_q <= 1'b1;
      end else begin
        wptr_q  <= wptr_q + PTR_W'(1);
        ready_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (load) begin
      weight_mem_q[wptr_q] <= weight_in;
    end
  end

  logic             win_valid_prev_q;
  logic [COL_W-1:0] col_q, col_cur;

  // Column of the window being presented now; a fresh burst starts at the first full column.
  always_comb begin
    if (!win_valid_prev_q) begin
      col_cur = COL_W'(KERNEL_SIZE - 1);
    end else if (col_q == COL_W'(ROW_SIZE - 1)) begin
      col_cur = '0;
    end else begin
      col_cur = col_q + COL_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      win_valid_prev_q <= 1'b0;
      col_q            <= '0;
    end else begin
      win_valid_prev_q <= window_valid;
      if (accept) begin
        col_q <= col_cur;
      end
    end
  end

  logic signed [PROD_W-1:0] prod_q [N];
  logic                     prod_valid_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prod_valid_q <= 1'b0;
    end else begin
      prod_valid_q <= accept && (col_cur >= COL_W'(KERNEL_SIZE - 1));
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < N; i++) begin
        prod_q[i] <= PROD_W'($signed({1'b0, window_in[i*DATA_SIZE +: DATA_SIZE]}))
                   * PROD_W'(weight_mem_q[i]);
      end
    end
  end

  mac_adder_tree #(
    .N        (N),
    .IN_W     (PROD_W),
    .OUT_W    (ACC),
    .CLAMP_NEG(RELU_EN)
  ) u_adder_tree (
    .clock    (clock),
    .resetn   (resetn),
    .terms    (prod_q),
    .in_valid (prod_valid_q),
    .sum      (pixel_out),
    .out_valid(pixel_valid)
  );

  assign weights_ready = ready_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed self-checking bench for conv_window_mac (K=3, D=8, W=8, ROW_SIZE=28).
module tb_conv_window_mac;

  localparam int K   = 3;
  localparam int D   = 8;
  localparam int W   = 8;
  localparam int N   = K * K;
  localparam int ACC = 21;

  logic                  clock = 1'b0;
  logic                  resetn = 1'b0;
  logic [N*D-1:0]        window_in = '0;
  logic                  window_valid = 1'b0;
  logic signed [W-1:0]   weight_in = '0;
  logic                  weight_valid = 1'b0;
  logic                  weights_ready;
  logic signed [ACC-1:0] pixel_out;
  logic                  pixel_valid;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  conv_window_mac #(
    .KERNEL_SIZE(K),
    .DATA_SIZE  (D),
    .ROW_SIZE   (28),
    .WEIGHT_SIZE(W)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .window_in    (window_in),
    .window_valid (window_valid),
    .weight_in    (weight_in),
    .weight_valid (weight_valid),
    .weights_ready(weights_ready),
    .pixel_out    (pixel_out),
    .pixel_valid  (pixel_valid)
  );

  function automatic logic [N*D-1:0] uniform(input logic [D-1:0] v);
    logic [N*D-1:0] r;
    for (int i = 0; i < N; i++) r[i*D +: D] = v;
    return r;
  endfunction

  task automatic load_weight(input logic signed [W-1:0] w);
    weight_in    = w;
    weight_valid = 1'b1;
    @(negedge clock);
    weight_valid = 1'b0;
  endtask

  task automatic load_all(input logic signed [W-1:0] w);
    for (int i = 0; i < N; i++) load_weight(w);
  endtask

  // Presents one window for one cycle and returns at the negedge where its result is due.
  task automatic one_window(input logic [N*D-1:0] win);
    window_in    = win;
    window_valid = 1'b1;
    @(negedge clock);
    window_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset;
    int pulses;
    resetn = 1'b0;
    @(negedge clock);
    compared++;
    if (pixel_out !== '0) begin
      mismatched++; $display("FAIL reset_pixel_out: got %0d expected 0", pixel_out);
    end
    compared++;
    if (pixel_valid !== 1'b0) begin
      mismatched++; $display("FAIL reset_pixel_valid: got %b expected 0", pixel_valid);
    end
    compared++;
    if (weights_ready !== 1'b0) begin
      mismatched++; $display("FAIL reset_weights_ready: got %b expected 0", weights_ready);
    end
    resetn = 1'b1;
    @(negedge clock);
    // Windows before any weights are loaded must be dropped.
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (pixel_valid === 1'b1) pulses++;
      window_in    = uniform(8'd5);
      window_valid = (k < 4);
      @(negedge clock);
    end
    compared++;
    if (pulses != 0) begin
      mismatched++; $display("FAIL unloaded_drop: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_ones;
    for (int i = 0; i < 8; i++) load_weight(8'sd1);
    compared++;
    if (weights_ready !== 1'b0) begin
      mismatched++; $display("FAIL ready_after_8: got %b expected 0", weights_ready);
    end
    load_weight(8'sd1);
    compared++;
    if (weights_ready !== 1'b1) begin
      mismatched++; $display("FAIL ready_after_9: got %b expected 1", weights_ready);
    end
    window_in    = uniform(8'd2);
    window_valid = 1'b1;
    @(negedge clock);
    compared++;
    if (pixel_valid !== 1'b0) begin
      mismatched++; $display("FAIL latency_early: got valid %b expected 0", pixel_valid);
    end
    @(negedge clock);
    compared++;
    if (pixel_valid !== 1'b1 || pixel_out !== 21'sd18) begin
      mismatched++;
      $display("FAIL ones_value: got valid %b out %0d expected 1 / 18", pixel_valid, pixel_out);
    end
    @(negedge clock);
    window_valid = 1'b0;
    compared++;
    if (pixel_valid !== 1'b1) begin
      mismatched++; $display("FAIL hold_valid: got %b expected 1", pixel_valid);
    end
    @(negedge clock);
    compared++;
    if (pixel_valid !== 1'b1 || pixel_out !== 21'sd18) begin
      mismatched++;
      $display("FAIL inflight_after_drop: got valid %b out %0d expected 1 / 18",
               pixel_valid, pixel_out);
    end
    @(negedge clock);
    compared++;
    if (pixel_valid !== 1'b0) begin
      mismatched++; $display("FAIL drained: got valid %b expected 0", pixel_valid);
    end
  endtask

  task automatic test_signed;
    logic [N*D-1:0]        win;
    logic signed [ACC-1:0] exp_o;
    // Weights -4..4 against pixels 1..9: sum of (i-4)(i+1) = 60.
    load_weight(-8'sd4);
    compared++;
    if (weights_ready !== 1'b0) begin
      mismatched++; $display("FAIL reload_deasserts_ready: got %b expected 0", weights_ready);
    end
    for (int i = 1; i < N; i++) load_weight(W'(i - 4));
    for (int i = 0; i < N; i++) win[i*D +: D] = D'(i + 1);
    one_window(win);
    compared++;
    if (pixel_valid !== 1'b1 || pixel_out !== 21'sd60) begin
      mismatched++;
      $display("FAIL ramp_value: got valid %b out %0d expected 1 / 60", pixel_valid, pixel_out);
    end

    for (int i = 0; i < N; i++) load_weight((i == 4) ? -8'sd1 : 8'sd0);
    win = uniform(8'd7);
    win[4*D +: D] = 8'd200;
    one_window(win);
`ifdef CONV_RELU_EN
    exp_o = 21'sd0;
`else
    exp_o = -21'sd200;
`endif
    compared++;
    if (pixel_valid !== 1'b1 || pixel_out !== exp_o) begin
      mismatched++;
      $display("FAIL center_neg: got valid %b out %0d expected 1 / %0d",
               pixel_valid, pixel_out, exp_o);
    end

    // Most negative corner: -128 * 255 * 9.
    load_all(8'h80);
    one_window(uniform(8'd255));
`ifdef CONV_RELU_EN
    exp_o = 21'sd0;
`else
    exp_o = -21'sd293760;
`endif
    compared++;
    if (pixel_valid !== 1'b1 || pixel_out !== exp_o) begin
      mismatched++;
      $display("FAIL extreme_neg: got valid %b out %0d expected 1 / %0d",
               pixel_valid, pixel_out, exp_o);
    end
  endtask

  task automatic test_row_wrap;
    int   pulses, bad;
    logic exp_v;
    load_all(8'sd1);
    pulses = 0;
    bad    = 0;
    for (int k = 0; k < 62; k++) begin
      // Sample k shows the window driven at k-2, whose column is k mod 28.
      exp_v = (k >= 2) && (k < 58) && ((k % 28) >= 2);
      if (pixel_valid !== exp_v) bad++;
      if (pixel_valid === 1'b1) begin
        pulses++;
        if (pixel_out !== 21'sd9) bad++;
      end
      window_in    = uniform(8'd1);
      window_valid = (k < 56);
      @(negedge clock);
    end
    compared++;
    if (pulses != 52) begin
      mismatched++; $display("FAIL row_wrap_count: got %0d pulses expected 52", pulses);
    end
    compared++;
    if (bad != 0) begin
      mismatched++; $display("FAIL row_wrap_pattern: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_drop_resume;
    int   pulses, bad, j;
    logic exp_v;
    pulses = 0;
    bad    = 0;
    for (int k = 0; k < 34; k++) begin
      j     = k - 2;
      exp_v = (j >= 0) && (j < 29) && (j != 25);
      if (pixel_valid !== exp_v) bad++;
      if (pixel_valid === 1'b1) begin
        pulses++;
        if (pixel_out !== ACC'(9 * (j + 1))) bad++;
      end
      window_in    = uniform(D'(k + 1));
      window_valid = (k < 29) && (k != 25);
      @(negedge clock);
    end
    compared++;
    if (pulses != 28) begin
      mismatched++; $display("FAIL drop_resume_count: got %0d pulses expected 28", pulses);
    end
    compared++;
    if (bad != 0) begin
      mismatched++; $display("FAIL drop_resume_pattern: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_weight_during_window;
    int pulses, bad;
    pulses = 0;
    bad    = 0;
    for (int k = 0; k < 6; k++) begin
      if (pixel_valid !== ((k >= 2) && (k < 5))) bad++;
      if (pixel_valid === 1'b1) begin
        pulses++;
        if (pixel_out !== 21'sd27) bad++;
      end
      window_in    = uniform(8'd3);
      window_valid = (k < 3);
      weight_in    = 8'sd0;
      weight_valid = (k < 3);
      @(negedge clock);
    end
    weight_valid = 1'b0;
    compared++;
    if (pulses != 3 || bad != 0) begin
      mismatched++;
      $display("FAIL weight_ignored_out: got %0d pulses %0d bad expected 3 / 0", pulses, bad);
    end
    compared++;
    if (weights_ready !== 1'b1) begin
      mismatched++; $display("FAIL weight_ignored_ready: got %b expected 1", weights_ready);
    end
    // wptr must still be at 0: only the ninth write completes the set.
    for (int i = 0; i < 8; i++) load_weight(8'sd2);
    compared++;
    if (weights_ready !== 1'b0) begin
      mismatched++; $display("FAIL wptr_unchanged_8: got %b expected 0", weights_ready);
    end
    load_weight(8'sd2);
    compared++;
    if (weights_ready !== 1'b1) begin
      mismatched++; $display("FAIL wptr_unchanged_9: got %b expected 1", weights_ready);
    end
    one_window(uniform(8'd1));
    compared++;
    if (pixel_valid !== 1'b1 || pixel_out !== 21'sd18) begin
      mismatched++;
      $display("FAIL twos_value: got valid %b out %0d expected 1 / 18", pixel_valid, pixel_out);
    end
  endtask

  task automatic test_reset_midload;
    int pulses;
    // A window in flight when reset hits must never emerge.
    window_in    = uniform(8'd4);
    window_valid = 1'b1;
    @(negedge clock);
    window_valid = 1'b0;
    resetn       = 1'b0;
    #1;
    compared++;
    if (pixel_valid !== 1'b0 || pixel_out !== '0) begin
      mismatched++;
      $display("FAIL reset_flush: got valid %b out %0d expected 0 / 0", pixel_valid, pixel_out);
    end
    @(negedge clock);
    resetn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      if (pixel_valid === 1'b1) pulses++;
      @(negedge clock);
    end
    compared++;
    if (pulses != 0) begin
      mismatched++; $display("FAIL reset_flush_late: got %0d pulses expected 0", pulses);
    end

    for (int i = 0; i < 5; i++) load_weight(8'sd5);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    compared++;
    if (weights_ready !== 1'b0) begin
      mismatched++; $display("FAIL midload_reset_ready: got %b expected 0", weights_ready);
    end
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (pixel_valid === 1'b1) pulses++;
      window_in    = uniform(8'd1);
      window_valid = (k < 6);
      @(negedge clock);
    end
    compared++;
    if (pulses != 0) begin
      mismatched++; $display("FAIL midload_windows_dropped: got %0d pulses expected 0", pulses);
    end
    // Four more writes must not be enough: the reset returned wptr to 0.
    for (int i = 0; i < 4; i++) load_weight(8'sd3);
    compared++;
    if (weights_ready !== 1'b0) begin
      mismatched++; $display("FAIL midload_partial: got %b expected 0", weights_ready);
    end
    for (int i = 0; i < 5; i++) load_weight(8'sd3);
    compared++;
    if (weights_ready !== 1'b1) begin
      mismatched++; $display("FAIL midload_full_reload: got %b expected 1", weights_ready);
    end
    one_window(uniform(8'd1));
    compared++;
    if (pixel_valid !== 1'b1 || pixel_out !== 21'sd27) begin
      mismatched++;
      $display("FAIL threes_value: got valid %b out %0d expected 1 / 27", pixel_valid, pixel_out);
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    test_reset();
    test_ones();
    test_signed();
    test_row_wrap();
    test_drop_resume();
    test_weight_during_window();
    test_reset_midload();
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
